ram_bist: RTL and testbench



---
 rtl/ram_bist.sv | 200 ++++++++++++++++++++
 tb/tb_ram_bist.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March C- built-in self-test controller for a single-port RAM with registered read data.
// Optional mismatch counter output err_count is enabled by defining RAM_BIST_ERRCNT_EN.
module ram_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_elem,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [ADDR_WIDTH+2:0] err_count,
`endif
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_DONE
    } state_t;

    typedef enum logic { PH_RD, PH_CHK } phase_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH+2:0] CNT_ONE   = (ADDR_WIDTH + 3)'(1);

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
    logic [2:0]              fail_elem_q, fail_elem_d;
    logic [ADDR_WIDTH+2:0]   cnt_q, cnt_d;

    logic                    in_march, descending, we_raw, re_raw, mismatch;
    logic [2:0]              elem;
    logic [DATA_WIDTH-1:0]   exp_val, wr_val;
    logic [ADDR_WIDTH-1:0]   end_addr;

    // Per-element background decode: what a read must return and what the CHK cycle writes back.
    always_comb begin
        in_march   = 1'b0;
        descending = 1'b0;
        elem       = 3'd0;
        exp_val    = '0;
        wr_val     = '0;
        case (state_q)
            S_E1: begin in_march = 1'b1; elem = 3'd1; exp_val = '0; wr_val = '1; end
            S_E2: begin in_march = 1'b1; elem = 3'd2; exp_val = '1; wr_val = '0; end
            S_E3: begin in_march = 1'b1; elem = 3'd3; exp_val = '0; wr_val = '1; descending = 1'b1; end
            S_E4: begin in_march = 1'b1; elem = 3'd4; exp_val = '1; wr_val = '0; descending = 1'b1; end
            S_E5: begin in_march = 1'b1; elem = 3'd5; exp_val = '0; descending = 1'b1; end
            default: ;
        endcase
        end_addr = descending ? '0 : ADDR_LAST;

        we_raw  = 1'b0;
        re_raw  = 1'b0;
        mem_din = '0;
        if (state_q == S_E0) begin
            we_raw = 1'b1;
        end else if (in_march) begin
            if (phase_q == PH_RD) begin
                re_raw = 1'b1;
            end else if (state_q != S_E5) begin
                we_raw  = 1'b1;
                mem_din = wr_val;
            end
        end
        mem_we   = we_raw & rst_n;
        mem_re   = re_raw & rst_n;
        mem_addr = addr_q;
        mismatch = in_march && (phase_q == PH_CHK) && (mem_dout != exp_val);
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;
        cnt_d       = cnt_q;

        // Only the first mismatch is captured; the run always continues to the end.
        if (mismatch) begin
            if (!err_q) begin
                fail_addr_d = addr_q;
                fail_data_d = mem_dout;
                fail_elem_d = elem;
            end
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_E0;
                    phase_d     = PH_RD;
                    addr_d      = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = 3'd0;
                    cnt_d       = '0;
                end
            end
            S_E0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_E1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            default: begin
                if (phase_q == PH_RD) begin
                    phase_d = PH_CHK;
                end else begin
                    phase_d = PH_RD;
                    if (addr_q != end_addr) begin
                        addr_d = descending ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                    end else begin
                        state_d = state_t'(state_q + 3'd1);
                        addr_d  = (state_q == S_E1) ? '0 : ADDR_LAST;
                        if (state_q == S_E5) begin
                            addr_d = '0;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            pass_d = ~err_d;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_RD;
            addr_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= 3'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;
`ifdef RAM_BIST_ERRCNT_EN
    assign err_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: RAM model with injectable faults, an abstract March C- model and per-cycle bus checks.
module tb_ram_bist;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int RUN   = DEPTH + 10 * DEPTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [2:0]    fail_elem;
`ifdef RAM_BIST_ERRCNT_EN
    logic [AW+2:0] err_count;
`endif
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
`ifdef RAM_BIST_ERRCNT_EN
        .err_count(err_count),
`endif
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    op_t           expQ[$];
    int            tests = 0;
    int            fails = 0;
    int            faultMode = 0;
    int            idx = 0;
    bit            checking = 1'b0;
    logic [DW-1:0] ramArr [DEPTH];

    logic          expPass;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    logic [2:0]    expElem;
    int            expCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Fault modes: 1 = bit 0 of address 5 stuck at 1, 2 = writes to address 9 also land in address 3.
    function automatic logic [DW-1:0] faultRead(input logic [AW-1:0] a, input logic [DW-1:0] raw);
        return (faultMode == 1 && a == AW'(5)) ? (raw | DW'(1)) : raw;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ramArr[mem_addr] = mem_din;
            if (faultMode == 2 && mem_addr == AW'(9)) ramArr[3] = mem_din;
        end else if (mem_re) begin
            mem_dout <= faultRead(mem_addr, ramArr[mem_addr]);
        end
    end

    task automatic buildExpected();
        op_t op;
        logic [DW-1:0] bg;
        expQ.delete();
        for (int a = 0; a < DEPTH; a++) begin
            op = '{we: 1'b1, re: 1'b0, addr: AW'(a), din: '0};
            expQ.push_back(op);
        end
        for (int e = 1; e <= 5; e++) begin
            bg = (e == 2 || e == 4) ? '1 : '0;
            for (int i = 0; i < DEPTH; i++) begin
                op = '{we: 1'b0, re: 1'b1, addr: AW'((e <= 2) ? i : DEPTH - 1 - i), din: '0};
                expQ.push_back(op);
                op.re  = 1'b0;
                op.we  = (e < 5);
                op.din = (e < 5) ? ~bg : '0;
                expQ.push_back(op);
            end
        end
    endtask

    // Abstract march over a shadow memory carrying the same fault, giving the expected verdict.
    task automatic computeExpected();
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] bg, r;
        int a;
        expPass = 1'b1; expAddr = '0; expData = '0; expElem = '0; expCnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = '0;
            if (faultMode == 2 && i == 9) m[3] = '0;
        end
        for (int e = 1; e <= 5; e++) begin
            bg = (e == 2 || e == 4) ? '1 : '0;
            for (int i = 0; i < DEPTH; i++) begin
                a = (e <= 2) ? i : DEPTH - 1 - i;
                r = faultRead(AW'(a), m[a]);
                if (r != bg) begin
                    if (expPass) begin
                        expAddr = AW'(a); expData = r; expElem = 3'(e);
                    end
                    expPass = 1'b0;
                    expCnt++;
                end
                if (e < 5) begin
                    m[a] = ~bg;
                    if (faultMode == 2 && a == 9) m[3] = ~bg;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (idx < expQ.size()) begin
                checkOutput($sformatf("bus cycle %0d", idx),
                            32'({busy, mem_we, mem_re, mem_addr, mem_we ? mem_din : 8'h00}),
                            32'({1'b1, expQ[idx].we, expQ[idx].re, expQ[idx].addr,
                                 expQ[idx].we ? expQ[idx].din : 8'h00}));
                idx++;
            end else begin
                checkOutput("busy after run", 32'(busy), 32'(0));
                checkOutput("done after run", 32'(done), 32'(1));
                checking = 1'b0;
            end
        end
    end

    task automatic applyStimulus();
        buildExpected();
        computeExpected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idx = 0;
        checking = 1'b1;
    endtask

    task automatic waitRunDone(input string name);
        int n = 0;
        while (checking && n < RUN + 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (checking) begin
            checkOutput({name, " timeout"}, 32'(idx), 32'(RUN + 1));
            checking = 1'b0;
        end
        checkOutput({name, " pass"}, 32'(pass), 32'(expPass));
        checkOutput({name, " fail_addr"}, 32'(fail_addr), 32'(expAddr));
        checkOutput({name, " fail_data"}, 32'(fail_data), 32'(expData));
        checkOutput({name, " fail_elem"}, 32'(fail_elem), 32'(expElem));
`ifdef RAM_BIST_ERRCNT_EN
        checkOutput({name, " err_count"}, 32'(err_count), 32'(expCnt));
`endif
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " busy"}, 32'(busy), 32'(0));
        checkOutput({name, " done"}, 32'(done), 32'(0));
        checkOutput({name, " pass"}, 32'(pass), 32'(0));
        checkOutput({name, " fail_*"}, 32'({fail_addr, fail_data, fail_elem}), 32'(0));
        checkOutput({name, " mem bus"}, 32'({mem_we, mem_re, mem_addr, mem_din}), 32'(0));
`ifdef RAM_BIST_ERRCNT_EN
        checkOutput({name, " err_count"}, 32'(err_count), 32'(0));
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ramArr[i] = '0;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        faultMode = 0;
        applyStimulus();
        waitRunDone("clean");
        checkOutput("clean pass literal", 32'(pass), 32'(1));
        checkOutput("clean elem literal", 32'(fail_elem), 32'(0));

        faultMode = 1;
        applyStimulus();
        waitRunDone("stuck");
        checkOutput("stuck pass literal", 32'(pass), 32'(0));
        checkOutput("stuck elem literal", 32'(fail_elem), 32'(1));
        checkOutput("stuck addr literal", 32'(fail_addr), 32'(5));
        checkOutput("stuck data literal", 32'(fail_data), 32'(8'h01));
`ifdef RAM_BIST_ERRCNT_EN
        checkOutput("stuck count literal", 32'(err_count), 32'(3));
`endif

        // Restart straight from DONE after a failing run.
        faultMode = 0;
        applyStimulus();
        checkOutput("restart done cleared", 32'(done), 32'(0));
        checkOutput("restart fail cleared", 32'({fail_addr, fail_data, fail_elem}), 32'(0));
        waitRunDone("restart");
        checkOutput("restart pass literal", 32'(pass), 32'(1));

        // Writes to 9 also hit 3: the E3 write at 9 corrupts 3 before E3 reads it.
        faultMode = 2;
        applyStimulus();
        waitRunDone("alias");
        checkOutput("alias addr literal", 32'(fail_addr), 32'(3));
        checkOutput("alias data literal", 32'(fail_data), 32'(8'hFF));
        checkOutput("alias elem literal", 32'(fail_elem), 32'(3));

        faultMode = 0;
        applyStimulus();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitRunDone("ignored start");

        applyStimulus();
        repeat (51) @(negedge clk);
        #2;
        checking = 1'b0;
        checkOutput("pre-reset re", 32'(mem_re), 32'(1));
        rst_n = 1'b0;
        #1;
        checkResetState("mid-run reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus();
        waitRunDone("after reset");
        checkOutput("after reset pass literal", 32'(pass), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
